led_bar_arbiter: RTL and testbench

Time-slicing arbiter that shares the badge's 8-LED bar (`cats`) between up to `N_REQ` challenge modules, such as the flag-shooting display. Each requester holds a request and an 8-bit pattern. The arbiter grants the bar round-robin for fixed slots and inserts a dark blanking gap between owners. It applies a global PWM brightness mask before the result drives the LED pins. It sits between the challenge modules and the top-level LED output.

---
 rtl/led_bar_arbiter.sv | 143 ++++++++++++++
 tb/tb_led_bar_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/led_bar_arbiter.sv
// Round-robin time-slicing owner of the 8-LED bar with a dark gap between owners
// and a global PWM brightness mask on the final drive.
module led_bar_arbiter #(
  parameter int N_REQ       = 4,
  parameter int SLOT_CYCLES = 24_000_000,
  parameter int GAP_CYCLES  = 4_800,
  parameter int PWM_BITS    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [8*N_REQ-1:0]         pattern,
  input  logic [PWM_BITS-1:0]        brightness,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   active_id,
  output logic [7:0]                 cats
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int SW   = $clog2(SLOT_CYCLES + 1);
  localparam int GW   = $clog2(GAP_CYCLES + 1);
  localparam logic [SW-1:0]   SLOT_LAST = SW'(SLOT_CYCLES - 1);
  localparam logic [GW-1:0]   GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [ID_W-1:0] ID_LAST   = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, SERVE, BLANK} state_e;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] id;
  } arb_t;

  state_e              state, state_d;
  logic [ID_W-1:0]     ptr, ptr_d, id_d, next_ptr;
  logic [N_REQ-1:0]    grant_d;
  logic [SW-1:0]       slot_cnt, slot_d;
  logic [GW-1:0]       gap_cnt, gap_d;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                slot_done, gap_done, owner_drop, serve_exit, pwm_on;
  arb_t                win;
  logic [7:0]          pat_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_pat
    assign pat_arr[i] = pattern[8*i +: 8];
  end

  // Descending scan so the requester closest to ptr is the last (winning) hit.
  function automatic arb_t arbitrate(input logic [N_REQ-1:0] r, input logic [ID_W-1:0] p);
    arb_t            a;
    logic [ID_W-1:0] idx;
    a = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(p) + k) % N_REQ);
      if (r[idx]) begin
        a.found = 1'b1;
        a.id    = idx;
      end
    end
    return a;
  endfunction

  assign win        = arbitrate(req, ptr);
  assign slot_done  = (slot_cnt == SLOT_LAST);
  assign gap_done   = (gap_cnt == GAP_LAST);
  assign owner_drop = !req[active_id];
  assign serve_exit = slot_done || owner_drop;
  assign next_ptr   = (active_id == ID_LAST) ? '0 : active_id + 1'b1;
  assign pwm_on     = (pwm_cnt < brightness) || (&brightness);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      active_id <= '0;
      grant     <= '0;
      slot_cnt  <= '0;
      gap_cnt   <= '0;
      pwm_cnt   <= '0;
      cats      <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      active_id <= id_d;
      grant     <= grant_d;
      slot_cnt  <= slot_d;
      gap_cnt   <= gap_d;
      pwm_cnt   <= pwm_cnt + 1'b1;
      // Pattern is sampled live so the owner can animate within its slot.
      cats      <= (state == SERVE && grant != '0 && pwm_on) ? pat_arr[active_id] : 8'h00;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (win.found) state_d = SERVE;
      SERVE:   if (serve_exit) state_d = BLANK;
      BLANK:   if (gap_done) state_d = win.found ? SERVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr;
    id_d    = active_id;
    grant_d = grant;
    slot_d  = slot_cnt;
    gap_d   = gap_cnt;
    case (state)
      IDLE: begin
        grant_d = '0;
        if (win.found) begin
          id_d    = win.id;
          grant_d = N_REQ'(1) << win.id;
          slot_d  = '0;
        end
      end
      SERVE: begin
        if (serve_exit) begin
          grant_d = '0;
          ptr_d   = next_ptr;
          gap_d   = '0;
        end else begin
          slot_d  = slot_cnt + 1'b1;
        end
      end
      BLANK: begin
        grant_d = '0;
        if (gap_done) begin
          if (win.found) begin
            id_d    = win.id;
            grant_d = N_REQ'(1) << win.id;
            slot_d  = '0;
          end
        end else begin
          gap_d = gap_cnt + 1'b1;
        end
      end
      default: grant_d = '0;
    endcase
  end

endmodule

// File: tb/tb_led_bar_arbiter.sv
// Directed bench for led_bar_arbiter: per-cycle vector table plus hand-timed
// reset, early-release, round-robin and PWM sequences.
module tb_led_bar_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] pattern = {8'hD4, 8'h5A, 8'h3C, 8'hA1};
  logic [3:0]  brightness = 4'hF;
  logic [3:0]  grant;
  logic [1:0]  active_id;
  logic [7:0]  cats;

  int tests = 0;
  int fails = 0;

  led_bar_arbiter #(.N_REQ(4), .SLOT_CYCLES(8), .GAP_CYCLES(2), .PWM_BITS(4)) dut (
    .clk(clk), .rst(rst), .req(req), .pattern(pattern), .brightness(brightness),
    .grant(grant), .active_id(active_id), .cats(cats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] bri;
    logic [3:0] g;
    logic [7:0] c;
    logic [1:0] id;
  } vec_t;

  vec_t tv [25];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int order [5];
    logic [3:0] eg;
    logic [7:0] ec;

    // Single requester full slots, early release to IDLE, late arrival in gap, brightness 0.
    tv[0] = '{4'b0100, 4'hF, 4'b0100, 8'h00, 2'd2};
    for (int i = 1; i < 8; i++) tv[i] = '{4'b0100, 4'hF, 4'b0100, 8'h5A, 2'd2};
    tv[8]  = '{4'b0100, 4'hF, 4'b0000, 8'h5A, 2'd2};
    tv[9]  = '{4'b0100, 4'hF, 4'b0000, 8'h00, 2'd2};
    tv[10] = '{4'b0100, 4'hF, 4'b0100, 8'h00, 2'd2};
    tv[11] = '{4'b0100, 4'hF, 4'b0100, 8'h5A, 2'd2};
    tv[12] = '{4'b0000, 4'hF, 4'b0000, 8'h5A, 2'd2};
    tv[13] = '{4'b0000, 4'hF, 4'b0000, 8'h00, 2'd2};
    tv[14] = '{4'b0000, 4'hF, 4'b0000, 8'h00, 2'd2};
    tv[15] = '{4'b0000, 4'hF, 4'b0000, 8'h00, 2'd2};
    tv[16] = '{4'b0001, 4'hF, 4'b0001, 8'h00, 2'd0};
    tv[17] = '{4'b0001, 4'hF, 4'b0001, 8'hA1, 2'd0};
    tv[18] = '{4'b0000, 4'hF, 4'b0000, 8'hA1, 2'd0};
    tv[19] = '{4'b0101, 4'hF, 4'b0000, 8'h00, 2'd0};
    tv[20] = '{4'b0101, 4'hF, 4'b0100, 8'h00, 2'd2};
    tv[21] = '{4'b0101, 4'hF, 4'b0100, 8'h5A, 2'd2};
    tv[22] = '{4'b0101, 4'h0, 4'b0100, 8'h00, 2'd2};
    tv[23] = '{4'b0101, 4'h0, 4'b0100, 8'h00, 2'd2};
    tv[24] = '{4'b0101, 4'hF, 4'b0100, 8'h5A, 2'd2};

    do_reset();
    chk("reset grant", 32'(grant), 32'h0);
    chk("reset cats", 32'(cats), 32'h0);
    chk("reset id", 32'(active_id), 32'h0);

    for (int i = 0; i < 25; i++) begin
      req = tv[i].req;
      brightness = tv[i].bri;
      tick();
      chk($sformatf("vec%0d grant", i), 32'(grant), 32'(tv[i].g));
      chk($sformatf("vec%0d cats", i), 32'(cats), 32'(tv[i].c));
      chk($sformatf("vec%0d id", i), 32'(active_id), 32'(tv[i].id));
    end

    // Asynchronous reset mid-SERVE, then first grant from ptr=0.
    req = 4'b0001;
    rst = 1'b1;
    #1;
    chk("async rst grant", 32'(grant), 32'h0);
    chk("async rst cats", 32'(cats), 32'h0);
    chk("async rst id", 32'(active_id), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post rst grant", 32'(grant), 32'h1);
    chk("post rst cats", 32'(cats), 32'h0);
    tick();
    chk("post rst cats2", 32'(cats), 32'hA1);

    // Early release of owner 1 hands off to 3 after the gap.
    req = 4'b1010;
    do_reset();
    tick();
    chk("er grant1", 32'(grant), 32'h2);
    chk("er id1", 32'(active_id), 32'h1);
    tick();
    tick();
    chk("er cats", 32'(cats), 32'h3C);
    req = 4'b1000;
    tick();
    chk("er drop grant", 32'(grant), 32'h0);
    chk("er drop cats", 32'(cats), 32'h3C);
    tick();
    chk("er gap grant", 32'(grant), 32'h0);
    chk("er gap cats", 32'(cats), 32'h0);
    tick();
    chk("er next grant", 32'(grant), 32'h8);
    chk("er next id", 32'(active_id), 32'h3);
    tick();
    chk("er next cats", 32'(cats), 32'hD4);

    // Round-robin with req=1011 held: 8-cycle slots, 2-cycle gaps, order 0,1,3,0,1.
    order = '{0, 1, 3, 0, 1};
    req = 4'b1011;
    do_reset();
    for (int n = 1; n <= 50; n++) begin
      tick();
      eg = (((n - 1) % 10) < 8) ? (4'b0001 << order[(n - 1) / 10]) : 4'b0000;
      ec = (n >= 2 && ((n - 2) % 10) < 8) ? pattern[8*order[(n - 2) / 10] +: 8] : 8'h00;
      chk($sformatf("rr%0d grant", n), 32'(grant), 32'(eg));
      chk($sformatf("rr%0d cats", n), 32'(cats), 32'(ec));
    end

    // PWM at brightness 4: cats lit only while pwm phase (edge-1)%16 < 4.
    pattern[7:0] = 8'hFF;
    brightness = 4'd4;
    req = 4'b0001;
    do_reset();
    for (int n = 1; n <= 200; n++) begin
      tick();
      eg = (((n - 1) % 10) < 8) ? 4'b0001 : 4'b0000;
      ec = (n >= 2 && ((n - 2) % 10) < 8 && ((n - 1) % 16) < 4) ? 8'hFF : 8'h00;
      chk($sformatf("pwm%0d grant", n), 32'(grant), 32'(eg));
      chk($sformatf("pwm%0d cats", n), 32'(cats), 32'(ec));
    end
    brightness = 4'd0;
    for (int n = 0; n < 20; n++) begin
      tick();
      chk($sformatf("dark%0d cats", n), 32'(cats), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
